// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pattern generator: pattern modes,
// colour-bar lookup and default 640x480@60 timing.
package vga_pkg;

    typedef enum logic [2:0] {
        MODE_SOLID  = 3'd0,
        MODE_BARS   = 3'd1,
        MODE_CHECK  = 3'd2,
        MODE_RAMP   = 3'd3,
        MODE_SCROLL = 3'd4
    } mode_e;

    // Pre-register timing flags for the pixel addressed by the counters
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
        logic frame_start;
    } tflags_t;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    // {R,G,B} flags, index 0 = white ... index 7 = black
    localparam logic [7:0][2:0] BAR_LUT = {
        3'b000,  // black
        3'b001,  // blue
        3'b100,  // red
        3'b101,  // magenta
        3'b010,  // green
        3'b011,  // cyan
        3'b110,  // yellow
        3'b111   // white
    };

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters and the unregistered sync, active and
// frame-start flags for the pixel currently addressed.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned XW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int unsigned YW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [XW-1:0] h_cnt,
    output logic [YW-1:0] v_cnt,
    output tflags_t       flags_c
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Raster counters: v advances on h wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == XW'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            if (v_cnt == YW'(V_TOTAL - 1)) begin
                v_cnt <= '0;
            end else begin
                v_cnt <= v_cnt + YW'(1);
            end
        end else begin
            h_cnt <= h_cnt + XW'(1);
        end
    end

    // Flags decoded from the counters; polarity is applied downstream
    always_comb begin
        flags_c             = '0;
        flags_c.active      = (h_cnt < XW'(H_ACTIVE)) && (v_cnt < YW'(V_ACTIVE));
        flags_c.hsync       = (h_cnt >= XW'(H_ACTIVE + H_FP)) &&
                              (h_cnt <  XW'(H_ACTIVE + H_FP + H_SYNC));
        flags_c.vsync       = (v_cnt >= YW'(V_ACTIVE + V_FP)) &&
                              (v_cnt <  YW'(V_ACTIVE + V_FP + V_SYNC));
        flags_c.frame_start = (h_cnt == '0) && (v_cnt == '0);
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA timing plus runtime-selectable test patterns; mode and solid colour
// are latched at the frame boundary, all outputs registered one cycle late.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BP       = DEF_H_BP,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter int unsigned SYNC_POL   = 0,
    parameter int unsigned COLOR_W    = 4,
    parameter int unsigned CHECK_LOG2 = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           i_mode,
    input  logic [3*COLOR_W-1:0] i_solid_rgb,
    output logic                 o_hsync,
    output logic                 o_vsync,
    output logic                 o_de,
    output logic [COLOR_W-1:0]   o_red,
    output logic [COLOR_W-1:0]   o_green,
    output logic [COLOR_W-1:0]   o_blue,
    output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0] o_x,
    output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0] o_y,
    output logic                 o_frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned XW      = $clog2(H_TOTAL);
    localparam int unsigned YW      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int unsigned BAR_W   = H_ACTIVE / 8;
    localparam int unsigned RAMP_SH = ($clog2(H_ACTIVE) > COLOR_W) ?
                                      ($clog2(H_ACTIVE) - COLOR_W) : 0;
    localparam logic        SYNC_ON = 1'(SYNC_POL);

    logic [XW-1:0]        h_cnt;
    logic [YW-1:0]        v_cnt;
    tflags_t              tf_c;

    logic [2:0]           mode_q;
    logic [3*COLOR_W-1:0] rgb_q;
    logic [7:0]           frame_cnt_q;
    logic                 first_q;
    logic [2:0]           bar_idx_q;
    logic [XW-1:0]        bar_pos_q;

    logic [2:0]           mode_c;
    logic [3*COLOR_W-1:0] rgb_c;
    logic [7:0]           frame_cnt_c;
    logic [2:0]           flags_rgb_c;
    logic [COLOR_W-1:0]   red_c;
    logic [COLOR_W-1:0]   green_c;
    logic [COLOR_W-1:0]   blue_c;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .XW       (XW),
        .YW       (YW)
    ) u_timing (
        .clk     (clk),
        .rst     (rst),
        .h_cnt   (h_cnt),
        .v_cnt   (v_cnt),
        .flags_c (tf_c)
    );

    // Pixel (0,0) already uses the values being captured for the new frame
    always_comb begin
        mode_c      = mode_q;
        rgb_c       = rgb_q;
        frame_cnt_c = frame_cnt_q;
        if (tf_c.frame_start) begin
            mode_c      = i_mode;
            rgb_c       = i_solid_rgb;
            frame_cnt_c = first_q ? frame_cnt_q : frame_cnt_q + 8'd1;
        end
    end

    // Pattern mux; blanking forces black outside the active window
    always_comb begin
        flags_rgb_c = BAR_LUT[bar_idx_q];
        red_c       = '0;
        green_c     = '0;
        blue_c      = '0;
        case (mode_c)
            MODE_SOLID: begin
                {red_c, green_c, blue_c} = rgb_c;
            end
            MODE_BARS: begin
                red_c   = {COLOR_W{flags_rgb_c[2]}};
                green_c = {COLOR_W{flags_rgb_c[1]}};
                blue_c  = {COLOR_W{flags_rgb_c[0]}};
            end
            MODE_CHECK: begin
                if ((h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]) == 1'b0) begin
                    red_c   = '1;
                    green_c = '1;
                    blue_c  = '1;
                end
            end
            MODE_RAMP: begin
                red_c   = COLOR_W'(h_cnt >> RAMP_SH);
                green_c = COLOR_W'(h_cnt >> RAMP_SH);
                blue_c  = COLOR_W'(h_cnt >> RAMP_SH);
            end
            MODE_SCROLL: begin
                flags_rgb_c = BAR_LUT[3'(bar_idx_q + frame_cnt_c[7:5])];
                red_c       = {COLOR_W{flags_rgb_c[2]}};
                green_c     = {COLOR_W{flags_rgb_c[1]}};
                blue_c      = {COLOR_W{flags_rgb_c[0]}};
            end
            default: begin
                red_c   = '0;
                green_c = '0;
                blue_c  = '0;
            end
        endcase
        if (!tf_c.active) begin
            red_c   = '0;
            green_c = '0;
            blue_c  = '0;
        end
    end

    // Frame-boundary latch, frame counter and bar tracker
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= '0;
            rgb_q       <= '0;
            frame_cnt_q <= '0;
            first_q     <= 1'b1;
            bar_idx_q   <= '0;
            bar_pos_q   <= '0;
        end else begin
            if (tf_c.frame_start) begin
                mode_q      <= i_mode;
                rgb_q       <= i_solid_rgb;
                frame_cnt_q <= frame_cnt_c;
                first_q     <= 1'b0;
            end
            // Tracks h_cnt / BAR_W without a divider, saturating at the last bar
            if (h_cnt == XW'(H_TOTAL - 1)) begin
                bar_idx_q <= '0;
                bar_pos_q <= '0;
            end else if (bar_pos_q == XW'(BAR_W - 1)) begin
                bar_pos_q <= '0;
                if (bar_idx_q != 3'd7) begin
                    bar_idx_q <= bar_idx_q + 3'd1;
                end
            end else begin
                bar_pos_q <= bar_pos_q + XW'(1);
            end
        end
    end

    // Output registers: every output describes the same pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            o_hsync       <= ~SYNC_ON;
            o_vsync       <= ~SYNC_ON;
            o_de          <= 1'b0;
            o_red         <= '0;
            o_green       <= '0;
            o_blue        <= '0;
            o_x           <= '0;
            o_y           <= '0;
            o_frame_start <= 1'b0;
        end else begin
            o_hsync       <= tf_c.hsync ? SYNC_ON : ~SYNC_ON;
            o_vsync       <= tf_c.vsync ? SYNC_ON : ~SYNC_ON;
            o_de          <= tf_c.active;
            o_red         <= red_c;
            o_green       <= green_c;
            o_blue        <= blue_c;
            o_x           <= h_cnt;
            o_y           <= v_cnt;
            o_frame_start <= tf_c.frame_start;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench: a reduced-timing instance runs hundreds of frames, a
// default 640x480 instance runs its first lines; both checked every cycle.
module tb_vga_pattern_gen;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic [9:0] x;
        logic [9:0] y;
        logic       fs;
    } pix_t;

    localparam int FR = 26 * 10;  // clocks per frame, small instance

    logic        clk;
    logic        rst;
    logic [2:0]  mode_s, mode_d;
    logic [11:0] rgb_s, rgb_d;

    logic       s_hs, s_vs, s_de, s_fs;
    logic [3:0] s_r, s_g, s_b;
    logic [4:0] s_x;
    logic [3:0] s_y;
    logic       d_hs, d_vs, d_de, d_fs;
    logic [3:0] d_r, d_g, d_b;
    logic [9:0] d_x;
    logic [9:0] d_y;

    int n_checks = 0;
    int n_errors = 0;

    pix_t q0[$];
    pix_t q1[$];

    int   mh[2], mv[2], mfc[2], mmode[2];
    bit   mfirst[2];
    logic [11:0] mrgb[2];

    int   cyc, fnum, phase;
    int   hs_fall, vs_fall, last_fs, de_cnt;
    bit   hper_done, hlen_done, vlen_done, fper_done;
    logic prev_dhs, prev_svs;

    vga_pattern_gen #(
        .H_ACTIVE(18), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(0),  .COLOR_W(4), .CHECK_LOG2(1)
    ) dut_s (
        .clk(clk), .rst(rst), .i_mode(mode_s), .i_solid_rgb(rgb_s),
        .o_hsync(s_hs), .o_vsync(s_vs), .o_de(s_de),
        .o_red(s_r), .o_green(s_g), .o_blue(s_b),
        .o_x(s_x), .o_y(s_y), .o_frame_start(s_fs)
    );

    vga_pattern_gen dut_d (
        .clk(clk), .rst(rst), .i_mode(mode_d), .i_solid_rgb(rgb_d),
        .o_hsync(d_hs), .o_vsync(d_vs), .o_de(d_de),
        .o_red(d_r), .o_green(d_g), .o_blue(d_b),
        .o_x(d_x), .o_y(d_y), .o_frame_start(d_fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [11:0] bar_color(input int idx);
        case (idx % 8)
            0:       return 12'hFFF;
            1:       return 12'hFF0;
            2:       return 12'h0FF;
            3:       return 12'h0F0;
            4:       return 12'hF0F;
            5:       return 12'hF00;
            6:       return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    // Reference model: expected output for the pixel clocked at the next edge
    task automatic model_step(input int d, input logic r, input logic [2:0] im,
                              input logic [11:0] irgb, output pix_t p);
        int ha, hfp, hsw, htot, va, vfp, vsw, vtot, cl, bar, sh;
        logic [11:0] c;
        logic [3:0]  g4;
        if (d == 0) begin
            ha = 18;  hfp = 2;  hsw = 4;  htot = 26;
            va = 6;   vfp = 1;  vsw = 2;  vtot = 10;  cl = 1;
        end else begin
            ha = 640; hfp = 16; hsw = 96; htot = 800;
            va = 480; vfp = 10; vsw = 2;  vtot = 525; cl = 5;
        end
        p = '0;
        if (r) begin
            p.hs = 1'b1;
            p.vs = 1'b1;
            mh[d] = 0; mv[d] = 0; mfc[d] = 0; mfirst[d] = 1'b1;
            mmode[d] = 0; mrgb[d] = 12'h000;
            return;
        end
        if (mh[d] == 0 && mv[d] == 0) begin
            p.fs = 1'b1;
            mmode[d] = int'(im);
            mrgb[d]  = irgb;
            if (mfirst[d]) mfirst[d] = 1'b0;
            else           mfc[d] = (mfc[d] + 1) % 256;
        end
        p.x  = 10'(mh[d]);
        p.y  = 10'(mv[d]);
        p.de = (mh[d] < ha) && (mv[d] < va);
        p.hs = !((mh[d] >= ha + hfp) && (mh[d] < ha + hfp + hsw));
        p.vs = !((mv[d] >= va + vfp) && (mv[d] < va + vfp + vsw));
        c = 12'h000;
        if (p.de) begin
            bar = mh[d] / (ha / 8);
            if (bar > 7) bar = 7;
            sh = ($clog2(ha) > 4) ? $clog2(ha) - 4 : 0;
            case (mmode[d])
                0: c = mrgb[d];
                1: c = bar_color(bar);
                2: c = ((((mh[d] >> cl) ^ (mv[d] >> cl)) & 1) == 0) ? 12'hFFF : 12'h000;
                3: begin
                    g4 = 4'((mh[d] >> sh) & 15);
                    c  = {g4, g4, g4};
                end
                4: c = bar_color(bar + (mfc[d] >> 5));
                default: c = 12'h000;
            endcase
        end
        {p.r, p.g, p.b} = c;
        mh[d]++;
        if (mh[d] == htot) begin
            mh[d] = 0;
            mv[d]++;
            if (mv[d] == vtot) mv[d] = 0;
        end
    endtask

    // One clock: push expectations, advance, pop and compare, directed checks
    task automatic step();
        pix_t e0, e1, g0, g1;
        logic rst_e;
        rst_e = rst;
        model_step(0, rst, mode_s, rgb_s, e0);
        q0.push_back(e0);
        model_step(1, rst, mode_d, rgb_d, e1);
        q1.push_back(e1);
        @(posedge clk);
        #1;
        g0 = {s_hs, s_vs, s_de, s_r, s_g, s_b, 10'(s_x), 10'(s_y), s_fs};
        g1 = {d_hs, d_vs, d_de, d_r, d_g, d_b, d_x, d_y, d_fs};
        check("pix_small", 64'(g0), 64'(q0.pop_front()));
        check("pix_default", 64'(g1), 64'(q1.pop_front()));

        if (rst_e) begin
            check("rst_outputs", 64'({d_hs, d_vs, d_de, d_r, d_g, d_b, d_x, d_y, d_fs}),
                  64'({2'b11, 1'b0, 12'h000, 20'h0, 1'b0}));
            cyc  = 0;
            fnum = -1;
        end else begin
            if (cyc == 0)
                check("first_after_rst", 64'({d_fs, d_x, d_y, d_de}), 64'({1'b1, 20'h0, 1'b1}));
            if (s_fs) begin
                fnum++;
                if (last_fs >= 0 && !fper_done) begin
                    check("frame_period", 64'(cyc - last_fs), 64'(FR));
                    fper_done = 1'b1;
                end
                last_fs = cyc;
                if (phase == 0 && fnum == 32)  check("scroll_f32",  64'({s_r, s_g, s_b}), 64'(12'hFF0));
                if (phase == 0 && fnum == 224) check("scroll_f224", 64'({s_r, s_g, s_b}), 64'(12'h000));
                if (phase == 0 && fnum == 256) check("scroll_wrap", 64'({s_r, s_g, s_b}), 64'(12'hFFF));
                if (phase == 1 && fnum == 0)   check("scroll_rst",  64'({s_r, s_g, s_b}), 64'(12'hFFF));
            end
            if (phase == 0 && fnum == 1 && s_y == 4'd0 && s_x == 5'd0)
                check("chk_0_0", 64'({s_r, s_g, s_b}), 64'(12'hFFF));
            if (phase == 0 && fnum == 1 && s_y == 4'd0 && s_x == 5'd2)
                check("chk_2_0", 64'({s_r, s_g, s_b}), 64'(12'h000));
            if (phase == 0 && fnum == 1 && s_y == 4'd2 && s_x == 5'd2)
                check("chk_2_2", 64'({s_r, s_g, s_b}), 64'(12'hFFF));
            if (phase == 0) begin
                case (cyc)
                    0:   check("bar_x0",   64'({d_r, d_g, d_b}), 64'(12'hFFF));
                    79:  check("bar_x79",  64'({d_r, d_g, d_b}), 64'(12'hFFF));
                    80:  check("bar_x80",  64'({d_r, d_g, d_b}), 64'(12'hFF0));
                    560: check("bar_x560", 64'({d_r, d_g, d_b}), 64'(12'h000));
                    639: check("bar_x639", 64'({d_r, d_g, d_b}), 64'(12'h000));
                    700: check("blank_x700", 64'({d_de, d_r, d_g, d_b}), 64'(13'h0));
                    default: ;
                endcase
                if (prev_dhs && !d_hs) begin
                    if (hs_fall < 0) check("hs_fall_x", 64'(d_x), 64'(656));
                    else if (!hper_done) begin
                        check("h_period", 64'(cyc - hs_fall), 64'(800));
                        hper_done = 1'b1;
                    end
                    hs_fall = cyc;
                end
                if (!prev_dhs && d_hs && hs_fall >= 0 && !hlen_done) begin
                    check("hs_len", 64'(cyc - hs_fall), 64'(96));
                    hlen_done = 1'b1;
                end
                if (cyc >= 800 && cyc < 1600 && d_de) de_cnt++;
                if (cyc == 1600) check("de_per_line", 64'(de_cnt), 64'(640));
                if (prev_svs && !s_vs) begin
                    if (vs_fall < 0) check("vs_fall_pos", 64'({s_y, s_x}), 64'({4'd7, 5'd0}));
                    vs_fall = cyc;
                end
                if (!prev_svs && s_vs && vs_fall >= 0 && !vlen_done) begin
                    check("vs_len", 64'(cyc - vs_fall), 64'(52));
                    vlen_done = 1'b1;
                end
            end
            cyc++;
        end
        prev_dhs = d_hs;
        prev_svs = s_vs;
    endtask

    initial begin
        cyc = 0; fnum = -1; phase = 0;
        hs_fall = -1; vs_fall = -1; last_fs = -1; de_cnt = 0;
        hper_done = 1'b0; hlen_done = 1'b0; vlen_done = 1'b0; fper_done = 1'b0;
        prev_dhs = 1'b1; prev_svs = 1'b1;
        rst = 1'b1; mode_s = 3'd1; rgb_s = 12'h000; mode_d = 3'd1; rgb_d = 12'h5A5;
        repeat (3) step();
        rst = 1'b0;
        // frame 0: bars; change mid-frame must not take effect until frame 1
        repeat (78) step();
        mode_s = 3'd2;
        mode_d = 3'd2;
        repeat (FR - 78) step();
        // frame 1: checkerboard
        repeat (FR / 2) step();
        mode_s = 3'd3;
        repeat (FR / 2) step();
        // frame 2: grey ramp
        repeat (FR / 2) step();
        mode_s = 3'd0;
        rgb_s  = 12'h3C9;
        repeat (FR / 2) step();
        // frame 3: solid, later rgb change ignored
        repeat (FR / 2) step();
        mode_s = 3'd6;
        rgb_s  = 12'hFFF;
        repeat (FR / 2) step();
        // frame 4: reserved mode -> black
        repeat (FR / 2) step();
        mode_s = 3'd4;
        repeat (FR / 2) step();
        // frames 5..258: scrolling bars through frame_cnt wrap
        repeat (254 * FR) step();
        // mid-frame reset, then scroll restarts from frame_cnt 0
        repeat (3 * 26 + 5) step();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        phase = 1;
        repeat (FR + 10) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
Parametrised successor to Simple_pattern: VGA timing generator plus selectable test-pattern engine. Timing, sync polarity and colour depth are parameters; pattern mode is selected at runtime and applied only at frame boundaries. Drives the board VGA pins directly and exposes pixel coordinates and data-enable for downstream overlay logic.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
SYNC_POL, 0, sync active level (0 = active-low)
COLOR_W, 4, bits per colour channel
CHECK_LOG2, 5, checkerboard square size = 2**CHECK_LOG2 pixels

Ports:
clk  in  1  pixel clock, single clock domain
rst  in  1  synchronous, active-high reset
i_mode  in  3  pattern select, sampled at frame start
i_solid_rgb  in  3*COLOR_W  {R,G,B} for solid mode, sampled at frame start
o_hsync  out  1  horizontal sync, SYNC_POL active
o_vsync  out  1  vertical sync, SYNC_POL active
o_de  out  1  active-video flag
o_red  out  COLOR_W  red channel
o_green  out  COLOR_W  green channel
o_blue  out  COLOR_W  blue channel
o_x  out  $clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)  horizontal counter of the pixel being output
o_y  out  $clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)  vertical counter of the pixel being output
o_frame_start  out  1  one-cycle pulse aligned with pixel (0,0)

Behaviour:
- H_TOTAL = sum of H params; V_TOTAL = sum of V params. h_cnt counts 0..H_TOTAL-1 and wraps; v_cnt increments on h_cnt wrap, counts 0..V_TOTAL-1 and wraps.
- Active: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE. hsync asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC. vsync asserted for the corresponding v_cnt range, whole lines.
- All outputs are registered with a fixed 1-cycle latency from the counters. o_x/o_y/o_de/syncs/colour all refer to the same pixel.
- Reset (any cycle, including mid-frame): h_cnt = v_cnt = 0, frame_cnt = 0, latched mode = 0, latched rgb = 0. Outputs: sync at inactive level, o_de = 0, colour = 0, o_x = o_y = 0, o_frame_start = 0. The first cycle after rst deasserts outputs pixel (0,0) with o_frame_start = 1.
- Mode latch: when h_cnt==0 && v_cnt==0, i_mode and i_solid_rgb are captured; this also holds for the first frame after reset. Mid-frame changes to the inputs have no effect until the next frame.
- frame_cnt: 8 bits, increments at every frame start except the first one after reset. Wraps 255 -> 0.
- Modes:
  - 0 = solid: latched rgb.
  - 1 = 8 colour bars. BAR_W = H_ACTIVE/8. The bar index is tracked incrementally (no divider) and saturates at 7 for any remainder pixels. Order: white, yellow, cyan, green, magenta, red, blue, black. Each channel is either all-ones or 0.
  - 2 = checkerboard: white when x[CHECK_LOG2] ^ y[CHECK_LOG2] == 0, else black.
  - 3 = horizontal grey ramp: all channels = (x >> ($clog2(H_ACTIVE)-COLOR_W)) truncated to COLOR_W.
  - 4 = scrolling bars: bar colour = LUT[(bar_idx + frame_cnt[7:5]) mod 8].
  - 5-7 = black.
- Outside the active region, colour is forced to 0 regardless of mode.

Decomposition:
- vga_pkg holds:
  - mode enum (MODE_SOLID..MODE_SCROLL)
  - 8-entry colour-bar LUT as 3-bit RGB flags, expanded to COLOR_W in RTL
  - default 640x480@60 timing constants
- Sub-module vga_timing owns h/v counters, sync, active and frame_start generation (pre-register).
- vga_pattern_gen owns the mode latch, frame_cnt, bar tracker, pattern mux and output registers.

Test Plan:
All tests use default parameters (H_TOTAL = 800, V_TOTAL = 525, 420000 clocks/frame).
1. Reset: hold rst for 3 clocks mid-frame -> o_hsync = o_vsync = 1, o_de = 0, RGB = 0 during reset. First cycle after release: o_frame_start = 1, o_x = 0, o_y = 0, o_de = 1.
2. Horizontal timing: measure o_hsync -> low for exactly 96 clocks, falling edge at o_x = 656, period 800. o_de high for exactly 640 clocks per active line.
3. Vertical timing: o_vsync low for exactly 1600 clocks starting at o_y = 490, o_x = 0. o_frame_start pulses every 420000 clocks.
4. Mode 1 colour bars, line 0:
   - x = 0..79 -> (F,F,F); x = 80 -> (F,F,0); x = 560..639 -> (0,0,0).
   - x = 640..799 -> (0,0,0) with o_de = 0.
5. Mid-frame mode change: frame in mode 1, set i_mode = 2 at line 100 -> remainder of frame stays bars. Next frame is checkerboard:
   - (0,0) -> white
   - (32,0) -> black
   - (32,32) -> white
6. Mode 4 scroll and wrap:
   - Frame 0: x = 0 -> white.
   - Frame 32: x = 0 -> yellow.
   - Frame 224: x = 0 -> black.
   - After 256 frames, frame_cnt = 0 and x = 0 -> white.
   - Assert rst mid-frame -> scroll restarts at frame_cnt = 0.
